// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the iterative multiply/divide engine: operation
// encodings, FSM state encodings, default operand width and op decode helpers.
package muldiv_sequencer_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CALC  = 2'b01,
    ST_FIXUP = 2'b10,
    ST_DONE  = 2'b11
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Pipeline <-> mult/div engine handshake. The pipeline side is the master,
// the sequencer is the slave.
interface muldiv_sequencer_if
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic             start;
  md_op_e           op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             divzero;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo, divzero
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo, divzero
  );

endinterface

// File: rtl/muldiv_sequencer_datapath.sv
// Radix-2 shift-add multiplier / restoring divider datapath. Holds the
// 2*WIDTH accumulator, operand magnitudes and sign flags, and produces the
// sign-corrected HI/LO result combinationally for the FIXUP cycle.
// Optional build macro: MULDIV_EARLY_EXIT_EN (multiply terminates once the
// remaining multiplier is zero; the product is realigned at fixup).
module muldiv_datapath
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CW-1:0]    count,
  output logic             calc_last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             res_dz
);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   mplr;
  logic [WIDTH-1:0]   raw_a;
  logic               sign_a;
  logic               sign_b;
  logic               is_div;

  logic               sa_in;
  logic               sb_in;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  assign sa_in = op_is_signed(op) & a[WIDTH-1];
  assign sb_in = op_is_signed(op) & b[WIDTH-1];
  assign mag_a = sa_in ? -a : a;
  assign mag_b = sb_in ? -b : b;

  // Multiplicand is added into the upper half; the carry becomes the new MSB.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplr[0] ? dvs : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // The shifted remainder can need WIDTH+1 bits, so the trial uses the bit
  // shifted out of the remainder as well; bit WIDTH of the result is the borrow.
  assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, dvs};
  assign div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

`ifdef MULDIV_EARLY_EXIT_EN
  assign calc_last = (count == CW'(1)) || (!is_div && (mplr[WIDTH-1:1] == '0));
  // Skipped iterations leave the product high in the accumulator.
  assign prod      = acc >> count;
`else
  assign calc_last = (count == CW'(1));
  assign prod      = acc;
`endif

  assign prod_fix = (sign_a ^ sign_b) ? -prod : prod;

  // Operand capture at start, then one multiply or divide iteration per step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      dvs    <= '0;
      mplr   <= '0;
      raw_a  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      is_div <= 1'b0;
    end else if (load) begin
      is_div <= op_is_div(op);
      sign_a <= sa_in;
      sign_b <= sb_in;
      raw_a  <= a;
      if (op_is_div(op)) begin
        acc  <= {{WIDTH{1'b0}}, mag_a};
        dvs  <= mag_b;
        mplr <= '0;
      end else begin
        acc  <= '0;
        dvs  <= mag_a;
        mplr <= mag_b;
      end
    end else if (step) begin
      if (is_div) begin
        acc <= div_next;
      end else begin
        acc  <= mul_next;
        mplr <= mplr >> 1;
      end
    end
  end

  // Sign correction and divide-by-zero override for the FIXUP cycle.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    res_dz = is_div && (dvs == '0);
    if (!is_div) begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end else if (res_dz) begin
      res_hi = raw_a;
      res_lo = '1;
    end else begin
      res_hi = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      res_lo = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multiply/divide sequencer for the execute stage: FSM, iteration counter,
// handshake and the HI/LO result registers around muldiv_datapath.
// Optional build macro: MULDIV_EARLY_EXIT_EN (handled in the datapath's
// calc_last / realignment logic).
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start; hi/lo hold the last result
// ST_CALC  | one multiply/divide iteration per cycle, count decrements
// ST_FIXUP | sign correction / div-by-zero override, registers hi/lo
// ST_DONE  | one-cycle done (and divzero) pulse, back to idle
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic              clk,
  input logic              reset,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_e        state_q;
  md_state_e        state_d;
  logic [CW-1:0]    count_q;
  logic             load;
  logic             step;
  logic             fix;
  logic             calc_last;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             res_dz;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             dz_q;

  muldiv_datapath #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .op        (bus.op),
    .a         (bus.a),
    .b         (bus.b),
    .count     (count_q),
    .calc_last (calc_last),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .res_dz    (res_dz)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath strobes; cancel wins over start and aborts
  // CALC/FIXUP without touching hi/lo.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.cancel) begin
          load    = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (bus.cancel) begin
          state_d = ST_IDLE;
        end else begin
          step = 1'b1;
          if (calc_last) state_d = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        if (bus.cancel) begin
          state_d = ST_IDLE;
        end else begin
          fix     = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Iteration down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    count_q <= '0;
    else if (load) count_q <= CW'(WIDTH);
    else if (step) count_q <= count_q - 1'b1;
  end

  // Result registers; only a completed FIXUP changes them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
      dz_q <= 1'b0;
    end else if (fix) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
      dz_q <= res_dz;
    end
  end

  assign bus.busy    = (state_q == ST_CALC) || (state_q == ST_FIXUP);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.divzero = (state_q == ST_DONE) && dz_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a vector table of operations with
// hand-computed HI/LO/divzero and latency, plus cancel, start+cancel,
// ignored start and mid-operation reset sequences.
// Optional build macro: MULDIV_EARLY_EXIT_EN (changes expected multiply latency).
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam int W = 32;

  typedef struct {
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          ign_at;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[12];

  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input md_op_e op, input logic [31:0] b);
    int          n;
    logic [31:0] m;
    n = 1;
    m = b;
`ifdef MULDIV_EARLY_EXIT_EN
    if (!op[1]) begin
      if (op == MD_MULT && b[31]) m = -b;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      return n + 2;
    end
`endif
    return W + 2;
  endfunction

  // Issues one operation; returns the cycle done was first seen (-1 on timeout).
  task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input int ign_at, output int lat, output logic busy_ok,
                        output logic dz_early);
    int cyc;
    @(posedge clk);
    #1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc       = 1;
    lat       = -1;
    busy_ok   = 1'b1;
    dz_early  = 1'b0;
    while (cyc < 100) begin
      if (bus.done) begin
        lat = cyc;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.divzero) dz_early = 1'b1;
      if (cyc == ign_at) begin
        bus.start = 1'b1;
        bus.op    = MD_MULTU;
        bus.a     = 32'h0000_0001;
        bus.b     = 32'h0000_0001;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.start = 1'b0;
  endtask

  task automatic count_dones(input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) n++;
    end
  endtask

  initial begin
    int          lat;
    logic        busy_ok;
    logic        dz_early;
    int          ndone;
    logic [31:0] hi_prev;
    logic [31:0] lo_prev;

    checks = 0;
    errors = 0;

    vecs[0]  = '{MD_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0};
    vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 10};
    vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0};
    vecs[3]  = '{MD_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0, 0};
    vecs[4]  = '{MD_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1, 0};
    vecs[5]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 0};
    vecs[6]  = '{MD_MULTU, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 32'h0000_000F, 1'b0, 0};
    vecs[7]  = '{MD_MULT,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0, 0};
    vecs[8]  = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 0};
    vecs[9]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 0};
    vecs[10] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 0};
    vecs[11] = '{MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, 0};

    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.op     = MD_MULT;
    bus.a      = '0;
    bus.b      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_divzero", 64'(bus.divzero), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 12; v++) begin
      run_op(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].ign_at, lat, busy_ok, dz_early);
      $display("vector %0d op=%0d a=%h b=%h", v, vecs[v].op, vecs[v].a, vecs[v].b);
      check("latency", 64'(lat), 64'(exp_lat(vecs[v].op, vecs[v].b)));
      check("busy_before_done", 64'(busy_ok), 64'd1);
      check("divzero_early", 64'(dz_early), 64'd0);
      check("hi", 64'(bus.hi), 64'(vecs[v].hi));
      check("lo", 64'(bus.lo), 64'(vecs[v].lo));
      check("divzero", 64'(bus.divzero), 64'(vecs[v].dz));
      check("busy_at_done", 64'(bus.busy), 64'd0);
      @(posedge clk);
      #1;
      check("done_single", 64'(bus.done), 64'd0);
      check("divzero_single", 64'(bus.divzero), 64'd0);
      if (vecs[v].ign_at != 0) begin
        count_dones(40, ndone);
        check("ignored_start_done", 64'(ndone), 64'd0);
        check("ignored_start_busy", 64'(bus.busy), 64'd0);
      end
    end

    // Cancel mid-divide: state drops in the next cycle, results untouched.
    hi_prev = bus.hi;
    lo_prev = bus.lo;
    @(posedge clk);
    #1;
    bus.op    = MD_DIV;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("cancel_busy_c10", 64'(bus.busy), 64'd1);
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    check("cancel_busy_c11", 64'(bus.busy), 64'd0);
    count_dones(40, ndone);
    check("cancel_no_done", 64'(ndone), 64'd0);
    check("cancel_hi_hold", 64'(bus.hi), 64'(hi_prev));
    check("cancel_lo_hold", 64'(bus.lo), 64'(lo_prev));

    // start and cancel together in IDLE: request is dropped.
    bus.op     = MD_MULTU;
    bus.a      = 32'd9;
    bus.b      = 32'd9;
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    check("start_cancel_busy", 64'(bus.busy), 64'd0);
    count_dones(40, ndone);
    check("start_cancel_no_done", 64'(ndone), 64'd0);

    // Reset in cycle 5 of a multiply: outputs clear without a clock edge.
    bus.op    = MD_MULTU;
    bus.a     = 32'd6;
    bus.b     = 32'd7;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_busy", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_hi", 64'(bus.hi), 64'd0);
    check("midrst_lo", 64'(bus.lo), 64'd0);
    check("midrst_divzero", 64'(bus.divzero), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    count_dones(40, ndone);
    check("midrst_no_done", 64'(ndone), 64'd0);

    // Recovery after reset.
    run_op(MD_MULTU, 32'd5, 32'd3, 0, lat, busy_ok, dz_early);
    check("recover_latency", 64'(lat), 64'(exp_lat(MD_MULTU, 32'd3)));
    check("recover_hi", 64'(bus.hi), 64'd0);
    check("recover_lo", 64'(bus.lo), 64'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
